can_bit_destuffer: RTL and testbench



---
 rtl/can_bit_destuffer_if.sv | 23 ++
 rtl/can_bit_destuffer.sv | 70 +++++++
 tb/tb_can_bit_destuffer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/can_bit_destuffer_if.sv
// Bit-stream link between the sample-point logic and the CAN destuffer.
// The master drives the sampled bits; the slave returns destuffed data and stuff status.
interface can_bit_destuffer_if #(
    parameter int CNT_W = 8
);
    logic             SP;
    logic             RX;
    logic             STF_EN;
    logic             BIT_OUT;
    logic             BIT_VALID;
    logic             F_STF;
    logic [CNT_W-1:0] STF_CNT;

    modport master (
        output SP, RX, STF_EN,
        input  BIT_OUT, BIT_VALID, F_STF, STF_CNT
    );

    modport slave (
        input  SP, RX, STF_EN,
        output BIT_OUT, BIT_VALID, F_STF, STF_CNT
    );
endinterface

// File: rtl/can_bit_destuffer.sv
// CAN receive-side bit destuffer: tracks runs of equal bits and flags the stuff bit that follows.
// Stuff bits are counted and dropped; every other sampled bit is forwarded with a one-clock strobe.
module can_bit_destuffer #(
    parameter int MAX_RUN = 5,
    parameter int CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    can_bit_destuffer_if.slave   bus
);
    localparam logic [2:0] RUN_LIMIT = 3'(MAX_RUN);

    logic             last_bit;
    logic [2:0]       run_cnt;
    logic [2:0]       run_next;
    logic             bit_out;
    logic             bit_valid;
    logic             f_stf;
    logic [CNT_W-1:0] stf_cnt;

    // A run of zero means "no run in progress", so the next bit always starts fresh.
    always_comb begin
        run_next = 3'd1;
        if (run_cnt != 3'd0 && bus.RX == last_bit)
            run_next = run_cnt + 3'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_bit  <= 1'b1;
            run_cnt   <= 3'd0;
            bit_out   <= 1'b1;
            bit_valid <= 1'b0;
            f_stf     <= 1'b0;
            stf_cnt   <= '0;
        end else begin
            bit_valid <= 1'b0;
            if (bus.SP) begin
                if (f_stf) begin
                    // Stuff bit: consumed even if it violates, and it seeds the next run.
                    f_stf    <= 1'b0;
                    last_bit <= bus.RX;
                    run_cnt  <= 3'd1;
                    if (stf_cnt != '1)
                        stf_cnt <= stf_cnt + CNT_W'(1);
                end else if (bus.STF_EN) begin
                    bit_out   <= bus.RX;
                    bit_valid <= 1'b1;
                    last_bit  <= bus.RX;
                    if (run_next == RUN_LIMIT) begin
                        f_stf   <= 1'b1;
                        run_cnt <= 3'd0;
                    end else begin
                        run_cnt <= run_next;
                    end
                end else begin
                    bit_out   <= bus.RX;
                    bit_valid <= 1'b1;
                    last_bit  <= bus.RX;
                    run_cnt   <= 3'd0;
                end
            end
        end
    end

    assign bus.BIT_OUT   = bit_out;
    assign bus.BIT_VALID = bit_valid;
    assign bus.F_STF     = f_stf;
    assign bus.STF_CNT   = stf_cnt;
endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed bench for can_bit_destuffer: a segment-queue model checked every cycle,
// plus literal expectations for pulse counts, streams and stuff counts.
module tb_can_bit_destuffer;
    localparam int MAX_RUN = 5;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    can_bit_destuffer_if #(.CNT_W(CNT_W)) bus ();

    can_bit_destuffer #(.MAX_RUN(MAX_RUN), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: the bits of the current stuffed segment; a stuff bit is due once the
    // last MAX_RUN bits of the segment are all equal.
    bit m_out, m_valid, m_stf;
    int m_cnt;
    bit seg[$];

    function automatic bit tail_equal();
        if (seg.size() < MAX_RUN) return 1'b0;
        for (int k = seg.size() - MAX_RUN; k < seg.size(); k++)
            if (seg[k] != seg[seg.size()-1]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_out = 1'b1; m_valid = 1'b0; m_stf = 1'b0; m_cnt = 0;
            seg.delete();
        end else begin
            m_valid = 1'b0;
            if (bus.SP) begin
                if (m_stf) begin
                    m_stf = 1'b0;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    seg.delete();
                    seg.push_back(bus.RX);
                end else if (bus.STF_EN) begin
                    m_out = bus.RX; m_valid = 1'b1;
                    seg.push_back(bus.RX);
                    if (tail_equal()) begin
                        m_stf = 1'b1;
                        seg.delete();
                    end
                end else begin
                    m_out = bus.RX; m_valid = 1'b1;
                    seg.delete();
                end
            end
        end
    end

    // Per-cycle compare plus pulse/stream capture, all on the falling edge.
    int vcount = 0;
    bit stream[$];
    always @(negedge clock) begin
        if (reset) begin
            check("bit_valid", int'(bus.BIT_VALID), int'(m_valid));
            check("bit_out",   int'(bus.BIT_OUT),   int'(m_out));
            check("f_stf",     int'(bus.F_STF),     int'(m_stf));
            check("stf_cnt",   int'(bus.STF_CNT),   m_cnt);
            if (bus.BIT_VALID) begin
                vcount++;
                stream.push_back(bus.BIT_OUT);
            end
        end
    end

    task automatic sp(input bit rx, input bit en);
        @(negedge clock);
        bus.SP = 1'b1; bus.RX = rx; bus.STF_EN = en;
        @(negedge clock);
        bus.SP = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        bus.SP = 1'b0; bus.RX = 1'b1; bus.STF_EN = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        vcount = 0;
        stream.delete();
    endtask

    initial begin
        bus.SP = 1'b0; bus.RX = 1'b1; bus.STF_EN = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_bit_out",   int'(bus.BIT_OUT),   1);
        check("rst_bit_valid", int'(bus.BIT_VALID), 0);
        check("rst_f_stf",     int'(bus.F_STF),     0);
        check("rst_stf_cnt",   int'(bus.STF_CNT),   0);

        // 1,1,1,1,1 then stuff 0 then 1
        do_reset();
        for (int i = 0; i < 5; i++) sp(1'b1, 1'b1);
        check("t1_fstf_after5", int'(bus.F_STF), 1);
        sp(1'b0, 1'b1);
        check("t1_fstf_after6", int'(bus.F_STF), 0);
        sp(1'b1, 1'b1);
        settle();
        check("t1_pulses", vcount, 6);
        check("t1_stf_cnt", int'(bus.STF_CNT), 1);
        for (int i = 0; i < stream.size(); i++) check("t1_stream", int'(stream[i]), 1);

        // 0x5, stuff 1, 1x4 -> second stuff, consumed by a trailing 0
        do_reset();
        for (int i = 0; i < 5; i++) sp(1'b0, 1'b1);
        sp(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) sp(1'b1, 1'b1);
        check("t2_fstf_pre", int'(bus.F_STF), 0);
        sp(1'b1, 1'b1);
        check("t2_fstf_second", int'(bus.F_STF), 1);
        sp(1'b0, 1'b1);
        settle();
        check("t2_pulses", vcount, 9);
        check("t2_stf_cnt", int'(bus.STF_CNT), 2);

        // violation: six zeros, then four more zeros reach the next stuff
        do_reset();
        for (int i = 0; i < 6; i++) sp(1'b0, 1'b1);
        check("t3_stf_cnt", int'(bus.STF_CNT), 1);
        check("t3_fstf_clear", int'(bus.F_STF), 0);
        for (int i = 0; i < 3; i++) sp(1'b0, 1'b1);
        check("t3_fstf_pre", int'(bus.F_STF), 0);
        sp(1'b0, 1'b1);
        check("t3_fstf_again", int'(bus.F_STF), 1);
        settle();
        check("t3_pulses", vcount, 9);

        // unstuffed region
        do_reset();
        for (int i = 0; i < 10; i++) sp(1'b1, 1'b0);
        settle();
        check("t4_pulses", vcount, 10);
        check("t4_stf_cnt", int'(bus.STF_CNT), 0);

        // stuff pending at end of stuffed region
        do_reset();
        for (int i = 0; i < 5; i++) sp(1'b1, 1'b1);
        sp(1'b1, 1'b0);
        settle();
        check("t5_pulses_stuff", vcount, 5);
        check("t5_stf_cnt", int'(bus.STF_CNT), 1);
        sp(1'b0, 1'b0);
        settle();
        check("t5_pulses_after", vcount, 6);
        check("t5_bit_out", int'(bus.BIT_OUT), 0);

        // asynchronous reset while a stuff bit is pending
        do_reset();
        for (int i = 0; i < 5; i++) sp(1'b0, 1'b1);
        check("t6_fstf_before", int'(bus.F_STF), 1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_fstf",    int'(bus.F_STF),     0);
        check("t6_async_bit_out", int'(bus.BIT_OUT),   1);
        check("t6_async_valid",   int'(bus.BIT_VALID), 0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) sp(1'b0, 1'b1);
        check("t6_fstf_after4", int'(bus.F_STF), 0);
        sp(1'b0, 1'b1);
        check("t6_fstf_after5", int'(bus.F_STF), 1);

        // counter saturation: a long run of zeros stuffs every five bits
        do_reset();
        for (int i = 0; i < 1400; i++) sp(1'b0, 1'b1);
        settle();
        check("t7_stf_cnt_sat", int'(bus.STF_CNT), CNT_MAX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
